// File: rtl/wb_spi_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : wb_spi_master_pkg
//  Description: Shared definitions for the Wishbone SPI master: register
//               word offsets (wb_adr_i[3:2]), STATUS bit positions and the
//               shift-engine state encoding.
//  Revision   : 1.0  initial release
// ============================================================================
package wb_spi_master_pkg;

    // Register select values (byte address bits [3:2])
    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_CTRL   = 2'd2;
    localparam logic [1:0] c_REG_CLKDIV = 2'd3;

    // STATUS bit positions
    localparam int c_STAT_BUSY = 0;
    localparam int c_STAT_RXV  = 1;
    localparam int c_STAT_OVR  = 2;

    // Shift-engine state: IDLE, SCK low half-period, SCK high half-period
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_spi_master_engine.sv
`default_nettype none
// ============================================================================
//  Module     : wb_spi_master_engine
//  Description: SPI mode-0 byte shifter, MSB first. Generates SCK from a
//               half-period down-counter reloaded from i_div.
//  Ports      : clk/rst      clock, async active-high reset
//               i_start      load i_tx_byte and begin a transfer (idle only)
//               i_tx_byte    byte to transmit
//               i_div        half-period length minus one
//               i_miso       serial input, sampled on SCK rise
//               o_busy       transfer in progress (registered)
//               o_done       final clk cycle of a transfer (combinational)
//               o_rx_byte    last received byte
//               o_sck/o_mosi serial clock / data, straight from flops
//  Revision   : 1.0  initial release
// ============================================================================
module wb_spi_master_engine
    import wb_spi_master_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [7:0]       i_tx_byte,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_miso,
    output logic             o_busy,
    output logic             o_done,
    output logic [7:0]       o_rx_byte,
    output logic             o_sck,
    output logic             o_mosi
);

    spi_state_t       r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx;
    logic             r_busy;
    logic             r_sck;
    logic             r_mosi;

    logic             w_half_end;

    assign w_half_end = (r_div_cnt == '0);
    // Completion is flagged during the last cycle so the wrapper can set
    // rx_valid on the same edge that drops busy.
    assign o_done     = (r_state == ST_HI) && w_half_end && (r_bit_cnt == 3'd0);

    assign o_busy     = r_busy;
    assign o_rx_byte  = r_rx;
    assign o_sck      = r_sck;
    assign o_mosi     = r_mosi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
            r_rx      <= 8'd0;
            r_busy    <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_shift   <= i_tx_byte;
                        r_bit_cnt <= 3'd7;
                        r_mosi    <= i_tx_byte[7];
                        r_sck     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_div_cnt <= i_div;
                        r_state   <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (w_half_end) begin
                        r_div_cnt <= i_div;
                        r_sck     <= 1'b1;
                        // Shifting left both samples MISO and exposes the
                        // next TX bit at [7] for the falling edge.
                        r_shift   <= {r_shift[6:0], i_miso};
                        r_state   <= ST_HI;
                    end else begin
                        r_div_cnt <= r_div_cnt - DIV_W'(1);
                    end
                end
                ST_HI: begin
                    if (w_half_end) begin
                        r_div_cnt <= i_div;
                        r_sck     <= 1'b0;
                        if (r_bit_cnt != 3'd0) begin
                            r_mosi    <= r_shift[7];
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            r_state   <= ST_LO;
                        end else begin
                            // MOSI deliberately holds the last bit.
                            r_rx    <= r_shift;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module     : wb_spi_master
//  Description: Wishbone slave SPI master (mode 0, 8-bit, MSB first).
//               Registers: 0x0 DATA, 0x4 STATUS {ovr,rx_valid,busy},
//               0x8 CTRL {cs_n}, 0xC CLKDIV.
//  Ports      : wb_clk/wb_rst         clock, async active-high reset
//               wb_adr_i/dat_i/we_i   bus request fields ([3:2] select)
//               wb_cyc_i/wb_stb_i     bus cycle / strobe
//               wb_ack_o/wb_dat_o     one-cycle ack, zero-extended data
//               spi_sck/mosi/cs_n     SPI outputs, all registered
//               spi_miso              SPI input
//  Revision   : 1.0  initial release
// ============================================================================
module wb_spi_master
    import wb_spi_master_pkg::*;
#(
    parameter int               DIV_W   = 8,
    parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(3)
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [3:0]  wb_adr_i,
    input  logic [7:0]  wb_dat_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_cs_n;
    logic             r_ovr;
    logic             r_rxv;
    logic [DIV_W-1:0] r_clkdiv;

    logic             w_req;
    logic [1:0]       w_sel;
    logic             w_start;
    logic             w_busy;
    logic             w_done;
    logic [7:0]       w_rx_byte;
    logic [31:0]      w_rdata;
    logic             w_unused_adr;

    // The ack term makes each access exactly two cycles and blocks
    // a held request from being taken twice.
    assign w_req        = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_sel        = wb_adr_i[3:2];
    assign w_start      = w_req & wb_we_i & (w_sel == c_REG_DATA) & ~w_busy;
    assign w_unused_adr = &{1'b0, wb_adr_i[1:0]};

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign spi_cs_n = r_cs_n;

    always_comb begin
        w_rdata = 32'd0;
        case (w_sel)
            c_REG_DATA:   w_rdata = {24'd0, w_rx_byte};
            c_REG_STATUS: w_rdata = {29'd0, r_ovr, r_rxv, w_busy};
            c_REG_CTRL:   w_rdata = {31'd0, r_cs_n};
            c_REG_CLKDIV: w_rdata = 32'(r_clkdiv);
            default:      w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
            r_cs_n   <= 1'b1;
            r_ovr    <= 1'b0;
            r_rxv    <= 1'b0;
            r_clkdiv <= DIV_RST;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_dat <= wb_we_i ? 32'd0 : w_rdata;
            end

            if (w_req && wb_we_i) begin
                case (w_sel)
                    c_REG_DATA: begin
                        // Busy includes the completion cycle, so a write
                        // coinciding with completion is also an overrun.
                        if (w_busy) begin
                            r_ovr <= 1'b1;
                        end
                    end
                    c_REG_STATUS: begin
                        if (wb_dat_i[c_STAT_OVR]) begin
                            r_ovr <= 1'b0;
                        end
                    end
                    c_REG_CTRL: begin
                        r_cs_n <= wb_dat_i[0];
                    end
                    c_REG_CLKDIV: begin
                        if (!w_busy) begin
                            r_clkdiv <= wb_dat_i[DIV_W-1:0];
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // A completing transfer wins over a simultaneous DATA read.
            if (w_done) begin
                r_rxv <= 1'b1;
            end else if (w_req && !wb_we_i && (w_sel == c_REG_DATA)) begin
                r_rxv <= 1'b0;
            end
        end
    end

    wb_spi_master_engine #(
        .DIV_W (DIV_W)
    ) u_engine (
        .clk       (wb_clk),
        .rst       (wb_rst),
        .i_start   (w_start),
        .i_tx_byte (wb_dat_i),
        .i_div     (r_clkdiv),
        .i_miso    (spi_miso),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_rx_byte (w_rx_byte),
        .o_sck     (spi_sck),
        .o_mosi    (spi_mosi)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_spi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : tb_wb_spi_master
//  Description: Self-checking bench for wb_spi_master. A timeline model
//               predicts ack, read data and SPI pin values every cycle;
//               directed sequences pin exact values, then random traffic.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_wb_spi_master;

    localparam logic [3:0] A_DATA   = 4'h0;
    localparam logic [3:0] A_STATUS = 4'h4;
    localparam logic [3:0] A_CTRL   = 4'h8;
    localparam logic [3:0] A_CLKDIV = 4'hC;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [3:0]  wb_adr_i = '0;
    logic [7:0]  wb_dat_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_n;

    // 0 = loopback from MOSI, 1 = tied high, 2 = random per cycle
    int   miso_mode = 0;
    logic miso_rnd  = 1'b0;
    assign spi_miso = (miso_mode == 0) ? spi_mosi :
                      (miso_mode == 1) ? 1'b1 : miso_rnd;

    always #5 wb_clk = ~wb_clk;

    wb_spi_master dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_ack_o (wb_ack_o),
        .wb_dat_o (wb_dat_o),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // A transfer is described by its start, a half-period length D and the
    // cycle index k since the start edge: SCK is high in odd half-periods,
    // MOSI carries bit 7-k/(2D), the whole thing lasts 16*D cycles.
    logic        m_ack, m_ack_rd, m_cs_n, m_ovr, m_rxv, m_sck, m_mosi, m_act;
    logic [31:0] m_dat;
    logic [7:0]  m_rx, m_div, m_tx, m_acc;
    int          m_k, m_D;

    function automatic void model_reset();
        m_ack = 0; m_ack_rd = 0; m_dat = 0; m_cs_n = 1; m_ovr = 0; m_rxv = 0;
        m_rx = 0; m_div = 8'd3; m_act = 0; m_k = 0; m_D = 4; m_tx = 0; m_acc = 0;
        m_sck = 0; m_mosi = 0;
    endfunction

    // Observation helpers used by directed sequences
    int          mon_rises = 0;
    int          mon_hi_run = 0;
    int          mon_last_hi = 0;
    logic [7:0]  mon_byte = 0;
    logic        prev_sck = 0;
    logic        prev_ack = 0;

    always @(negedge wb_clk) begin : model_cmp
        logic        req, busy_now, done, rd_clr;
        logic [31:0] rv;
        int          kn;

        if (wb_rst) model_reset();

        check("ack",  wb_ack_o, m_ack);
        check("sck",  spi_sck,  m_sck);
        check("mosi", spi_mosi, m_mosi);
        check("cs_n", spi_cs_n, m_cs_n);
        check("ack_pulse", prev_ack & wb_ack_o, 0);
        if (wb_ack_o && m_ack_rd) check("rdata", wb_dat_o, m_dat);
        if (wb_rst) check("dat_rst", wb_dat_o, 0);

        if (spi_sck && !prev_sck) begin
            mon_rises++;
            mon_byte = {mon_byte[6:0], spi_mosi};
        end
        if (spi_sck) mon_hi_run++;
        else if (prev_sck) begin mon_last_hi = mon_hi_run; mon_hi_run = 0; end
        prev_sck = spi_sck;
        prev_ack = wb_ack_o;

        if (!wb_rst) begin
            busy_now = m_act;
            req      = wb_cyc_i && wb_stb_i && !m_ack;
            done     = 0;
            rd_clr   = 0;
            rv       = 0;
            if (req && !wb_we_i) begin
                case (wb_adr_i[3:2])
                    2'd0: begin rv = {24'd0, m_rx}; rd_clr = 1; end
                    2'd1: rv = {29'd0, m_ovr, m_rxv, busy_now};
                    2'd2: rv = {31'd0, m_cs_n};
                    default: rv = {24'd0, m_div};
                endcase
            end
            // advance the transfer timeline across the coming edge
            if (m_act) begin
                kn = m_k + 1;
                if (kn % (2 * m_D) == m_D) m_acc = {m_acc[6:0], spi_miso};
                if (kn == 16 * m_D) begin
                    done = 1; m_act = 0; m_sck = 0;
                end else begin
                    m_sck  = ((kn / m_D) % 2) == 1;
                    m_mosi = m_tx[7 - kn / (2 * m_D)];
                end
                m_k = kn;
            end
            if (req && wb_we_i) begin
                case (wb_adr_i[3:2])
                    2'd0: begin
                        if (busy_now) m_ovr = 1;
                        else begin
                            m_act = 1; m_k = 0; m_D = int'(m_div) + 1; m_tx = wb_dat_i;
                            m_acc = 0; m_sck = 0; m_mosi = wb_dat_i[7];
                        end
                    end
                    2'd1: if (wb_dat_i[2]) m_ovr = 0;
                    2'd2: m_cs_n = wb_dat_i[0];
                    default: if (!busy_now) m_div = wb_dat_i;
                endcase
            end
            if (rd_clr) m_rxv = 0;
            if (done) begin m_rxv = 1; m_rx = m_acc; end
            m_ack    = req;
            m_ack_rd = req && !wb_we_i;
            if (m_ack_rd) m_dat = rv;
        end
    end

    always @(posedge wb_clk) begin
        #1 miso_rnd = 1'($urandom);
    end

    // ---------------- bus tasks ----------------
    task automatic bus(input logic [3:0] adr, input logic we, input logic [7:0] wd,
                       output logic [31:0] rd);
        int t;
        @(posedge wb_clk); #1;
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = wd; wb_cyc_i = 1; wb_stb_i = 1;
        t = 0;
        do begin @(posedge wb_clk); #1; t++; end while (!wb_ack_o && t < 4);
        check("ack_seen", wb_ack_o, 1);
        rd = wb_dat_o;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [7:0] wd);
        logic [31:0] d;
        bus(adr, 1'b1, wd, d);
    endtask

    task automatic rd(input logic [3:0] adr, output logic [31:0] d);
        bus(adr, 1'b0, 8'd0, d);
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int n;
        n = 0;
        do begin rd(A_STATUS, s); n++; end while (s[0] && n < 400);
        check("idle_timeout", {31'd0, s[0]}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [31:0] d;
        int r0, n, op;
        logic [3:0] adr;

        repeat (3) @(posedge wb_clk);
        #1;
        check("rst_sck", spi_sck, 0);
        check("rst_cs_n", spi_cs_n, 1);
        wb_rst = 0;

        // reset values
        rd(A_STATUS, d); check("status_rst", d, 32'h0);
        rd(A_CLKDIV, d); check("clkdiv_rst", d, 32'h3);
        rd(A_CTRL, d);   check("ctrl_rst", d, 32'h1);
        rd(A_DATA, d);   check("data_rst", d, 32'h0);

        // loopback, fastest SCK
        miso_mode = 0;
        wr(A_CLKDIV, 8'd0);
        r0 = mon_rises;
        wr(A_DATA, 8'hA5);
        wait_idle();
        check("a5_pulses", mon_rises - r0, 8);
        rd(A_STATUS, d); check("a5_status_pre", d, 32'h2);
        rd(A_DATA, d);   check("a5_rx", d, 32'hA5);
        rd(A_STATUS, d); check("a5_status_post", d, 32'h0);

        // MISO tied high, 4-cycle half periods
        miso_mode = 1;
        wr(A_CLKDIV, 8'd3);
        wr(A_DATA, 8'h3C);
        wait_idle();
        check("3c_mosi", mon_byte, 32'h3C);
        check("3c_hi_len", mon_last_hi, 4);
        rd(A_DATA, d); check("3c_rx", d, 32'hFF);

        // overrun
        miso_mode = 0;
        wr(A_DATA, 8'h11);
        wr(A_DATA, 8'h22);
        rd(A_STATUS, d); check("ovr_status", d, 32'h5);
        wait_idle();
        rd(A_STATUS, d); check("ovr_status_done", d, 32'h6);
        wr(A_STATUS, 8'h04);
        rd(A_STATUS, d); check("ovr_cleared", d, 32'h2);
        rd(A_DATA, d);   check("ovr_rx", d, 32'h11);

        // chip select and CLKDIV lock
        wr(A_CTRL, 8'h00); check("cs_low", spi_cs_n, 0);
        rd(A_CTRL, d);     check("ctrl_rd0", d, 32'h0);
        wr(A_CTRL, 8'h01); check("cs_high", spi_cs_n, 1);
        wr(A_DATA, 8'h77);
        wr(A_CLKDIV, 8'h09);
        rd(A_CLKDIV, d); check("clkdiv_locked", d, 32'h3);
        wait_idle();
        rd(A_DATA, d);   check("77_rx", d, 32'h77);

        // reset in the middle of a transfer
        wr(A_CTRL, 8'h00);
        r0 = mon_rises;
        wr(A_DATA, 8'hFF);
        n = 0;
        while (mon_rises - r0 < 4 && n < 200) begin @(negedge wb_clk); n++; end
        check("mid_rises", mon_rises - r0, 4);
        @(posedge wb_clk); #3;
        wb_rst = 1;
        #1;
        check("arst_sck", spi_sck, 0);
        check("arst_mosi", spi_mosi, 0);
        check("arst_cs_n", spi_cs_n, 1);
        check("arst_ack", wb_ack_o, 0);
        repeat (3) @(posedge wb_clk);
        #1 wb_rst = 0;
        rd(A_STATUS, d); check("post_rst_status", d, 32'h0);
        rd(A_CLKDIV, d); check("post_rst_clkdiv", d, 32'h3);
        wr(A_DATA, 8'h5A);
        wait_idle();
        rd(A_DATA, d);   check("post_rst_rx", d, 32'h5A);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) miso_mode = $urandom_range(0, 2);
            op  = $urandom_range(0, 9);
            adr = {2'b00, 2'($urandom)};
            case (op)
                0, 1, 2: wr({2'd0, adr[1:0]}, 8'($urandom));
                3:       rd({2'd0, adr[1:0]}, d);
                4:       rd({2'd1, adr[1:0]}, d);
                5:       wr({2'd1, adr[1:0]}, 8'($urandom));
                6:       wr({2'd2, adr[1:0]}, 8'($urandom));
                7:       wr({2'd3, adr[1:0]}, 8'($urandom_range(0, 3)));
                8:       rd({2'd3, adr[1:0]}, d);
                default: begin
                    @(posedge wb_clk); #1;
                    wb_cyc_i = 1'($urandom);
                    wb_stb_i = 0;
                    repeat ($urandom_range(1, 6)) @(posedge wb_clk);
                    #1 wb_cyc_i = 0;
                end
            endcase
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
